// File: rtl/emif_mailbox.sv
`default_nettype none
// ----------------------------------------------------------------------------
// emif_mailbox : EMIF register mailbox, command/response FIFOs to the fabric.
// Rev 1.0
// ----------------------------------------------------------------------------
module emif_mailbox #(
   parameter int          FIFO_AW   = 4,
   parameter logic [15:0] BASE_ADDR = 16'h0000
) (
   input  logic        clk_ref,
   input  logic        rst_n,
   input  logic        emif_dpram_wen,
   input  logic        emif_dpram_ren_2,
   input  logic [23:0] emif_dpram_addr,
   input  logic [15:0] emif_dpram_wdata,
   output logic [15:0] emif_dpram_rdata,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [15:0] cmd_data,
   input  logic        rsp_valid,
   output logic        rsp_ready,
   input  logic [15:0] rsp_data,
   output logic        irq_o
);

   localparam int                DEPTH    = 1 << FIFO_AW;
   localparam int                CW       = FIFO_AW + 1;
   localparam logic [FIFO_AW-1:0] PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]     CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
   localparam logic [CW-1:0]     CNT_FULL = {1'b1, {FIFO_AW{1'b0}}};

   localparam logic [7:0] OFF_CMD     = 8'h00;
   localparam logic [7:0] OFF_RSP     = 8'h01;
   localparam logic [7:0] OFF_STATUS  = 8'h02;
   localparam logic [7:0] OFF_CTRL    = 8'h03;
   localparam logic [7:0] OFF_SCRATCH = 8'h04;

   logic [15:0]        cmd_mem_q [DEPTH];
   logic [15:0]        rsp_mem_q [DEPTH];

   logic [FIFO_AW-1:0] cmd_wptr_q, cmd_wptr_d, cmd_rptr_q, cmd_rptr_d;
   logic [FIFO_AW-1:0] rsp_wptr_q, rsp_wptr_d, rsp_rptr_q, rsp_rptr_d;
   logic [CW-1:0]      cmd_cnt_q, cmd_cnt_d, rsp_cnt_q, rsp_cnt_d;
   logic               cmd_ovf_q, cmd_ovf_d, rsp_udf_q, rsp_udf_d;
   logic               irq_en_q, irq_en_d;
   logic               ren_2_q, ren_2_d;
   logic [15:0]        scratch_q, scratch_d;
   logic [15:0]        rdata_q, rdata_d;

   logic               sel, rd_stb;
   logic [7:0]         off;
   logic               wr_cmd, wr_status, wr_ctrl, wr_scratch, rd_rsp;
   logic               cmd_full, cmd_empty, rsp_full, rsp_empty;
   logic               cmd_push, cmd_pop, rsp_push, rsp_pop, flush;
   logic [4:0]         rsp_cnt5;
   logic [15:0]        status;

   assign sel        = (emif_dpram_addr[23:8] == BASE_ADDR);
   assign off        = emif_dpram_addr[7:0];
   assign rd_stb     = emif_dpram_ren_2 & ~ren_2_q;

   assign wr_cmd     = emif_dpram_wen & sel & (off == OFF_CMD);
   assign wr_status  = emif_dpram_wen & sel & (off == OFF_STATUS);
   assign wr_ctrl    = emif_dpram_wen & sel & (off == OFF_CTRL);
   assign wr_scratch = emif_dpram_wen & sel & (off == OFF_SCRATCH);
   assign rd_rsp     = rd_stb & sel & (off == OFF_RSP);

   assign cmd_full   = (cmd_cnt_q == CNT_FULL);
   assign cmd_empty  = (cmd_cnt_q == '0);
   assign rsp_full   = (rsp_cnt_q == CNT_FULL);
   assign rsp_empty  = (rsp_cnt_q == '0);

   // Fullness is judged on the registered count, so a push into a full FIFO
   // is refused even when a pop happens in the same cycle.
   assign cmd_push   = wr_cmd & ~cmd_full;
   assign cmd_pop    = cmd_valid & cmd_ready;
   assign rsp_push   = rsp_valid & rsp_ready;
   assign rsp_pop    = rd_rsp & ~rsp_empty;
   assign flush      = wr_ctrl & emif_dpram_wdata[1];

   assign cmd_valid  = ~cmd_empty;
   assign cmd_data   = cmd_mem_q[cmd_rptr_q];
   assign rsp_ready  = ~rsp_full;
   assign irq_o      = irq_en_q & ~rsp_empty;
   assign emif_dpram_rdata = rdata_q;

   assign rsp_cnt5   = 5'(rsp_cnt_q);
   assign status     = {3'b000, rsp_cnt5, 2'b00, rsp_udf_q, cmd_ovf_q,
                        rsp_empty, rsp_full, cmd_empty, cmd_full};

   always_comb begin
      cmd_wptr_d = cmd_wptr_q;
      cmd_rptr_d = cmd_rptr_q;
      cmd_cnt_d  = cmd_cnt_q;
      rsp_wptr_d = rsp_wptr_q;
      rsp_rptr_d = rsp_rptr_q;
      rsp_cnt_d  = rsp_cnt_q;

      if (cmd_push) cmd_wptr_d = cmd_wptr_q + PTR_ONE;
      if (cmd_pop)  cmd_rptr_d = cmd_rptr_q + PTR_ONE;
      unique case ({cmd_push, cmd_pop})
         2'b10:   cmd_cnt_d = cmd_cnt_q + CNT_ONE;
         2'b01:   cmd_cnt_d = cmd_cnt_q - CNT_ONE;
         default: cmd_cnt_d = cmd_cnt_q;
      endcase

      if (rsp_push) rsp_wptr_d = rsp_wptr_q + PTR_ONE;
      if (rsp_pop)  rsp_rptr_d = rsp_rptr_q + PTR_ONE;
      unique case ({rsp_push, rsp_pop})
         2'b10:   rsp_cnt_d = rsp_cnt_q + CNT_ONE;
         2'b01:   rsp_cnt_d = rsp_cnt_q - CNT_ONE;
         default: rsp_cnt_d = rsp_cnt_q;
      endcase

      if (flush) begin
         cmd_wptr_d = '0;
         cmd_rptr_d = '0;
         cmd_cnt_d  = '0;
         rsp_wptr_d = '0;
         rsp_rptr_d = '0;
         rsp_cnt_d  = '0;
      end
   end

   always_comb begin
      ren_2_d   = emif_dpram_ren_2;
      cmd_ovf_d = cmd_ovf_q;
      rsp_udf_d = rsp_udf_q;
      irq_en_d  = irq_en_q;
      scratch_d = scratch_q;
      rdata_d   = rdata_q;

      if (wr_status) begin
         if (emif_dpram_wdata[4]) cmd_ovf_d = 1'b0;
         if (emif_dpram_wdata[5]) rsp_udf_d = 1'b0;
      end
      if (wr_cmd & cmd_full)  cmd_ovf_d = 1'b1;
      if (rd_rsp & rsp_empty) rsp_udf_d = 1'b1;
      if (wr_ctrl)            irq_en_d  = emif_dpram_wdata[0];
      if (wr_scratch)         scratch_d = emif_dpram_wdata;

      // Read data is captured once per access and held until the next strobe.
      if (rd_stb) begin
         rdata_d = 16'h0000;
         if (sel) begin
            unique case (off)
               OFF_RSP:     if (!rsp_empty) rdata_d = rsp_mem_q[rsp_rptr_q];
               OFF_STATUS:  rdata_d = status;
               OFF_CTRL:    rdata_d = {15'h0000, irq_en_q};
               OFF_SCRATCH: rdata_d = scratch_q;
               default:     rdata_d = 16'h0000;
            endcase
         end
      end
   end

   // ren_2_q resets high so an access in flight across reset never strobes.
   always_ff @(posedge clk_ref or negedge rst_n) begin
      if (!rst_n) begin
         cmd_wptr_q <= '0;
         cmd_rptr_q <= '0;
         cmd_cnt_q  <= '0;
         rsp_wptr_q <= '0;
         rsp_rptr_q <= '0;
         rsp_cnt_q  <= '0;
         cmd_ovf_q  <= 1'b0;
         rsp_udf_q  <= 1'b0;
         irq_en_q   <= 1'b0;
         ren_2_q    <= 1'b1;
         scratch_q  <= 16'h0000;
         rdata_q    <= 16'h0000;
      end else begin
         cmd_wptr_q <= cmd_wptr_d;
         cmd_rptr_q <= cmd_rptr_d;
         cmd_cnt_q  <= cmd_cnt_d;
         rsp_wptr_q <= rsp_wptr_d;
         rsp_rptr_q <= rsp_rptr_d;
         rsp_cnt_q  <= rsp_cnt_d;
         cmd_ovf_q  <= cmd_ovf_d;
         rsp_udf_q  <= rsp_udf_d;
         irq_en_q   <= irq_en_d;
         ren_2_q    <= ren_2_d;
         scratch_q  <= scratch_d;
         rdata_q    <= rdata_d;
      end
   end

   always_ff @(posedge clk_ref) begin
      if (cmd_push) cmd_mem_q[cmd_wptr_q] <= emif_dpram_wdata;
      if (rsp_push) rsp_mem_q[rsp_wptr_q] <= rsp_data;
   end

endmodule
`default_nettype wire
